// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues word fetches on the shared memory port and
// buffers returned instructions with their PC in a small FIFO ahead of decode.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt,
  input  logic                         stall,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [31:0]                  mem_rdata,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    pend_pc_q, pend_pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    pc_mem_q   [DEPTH];
  logic [31:0]    pc_mem_d   [DEPTH];
  logic [31:0]    inst_mem_q [DEPTH];
  logic [31:0]    inst_mem_d [DEPTH];

  logic [CW:0]    occupancy;
  logic           grant;
  logic           push;
  logic           pop;

  // Slots already spoken for: buffered entries plus the response due this cycle.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(state_q == ST_PEND);

  assign mem_req    = !reset && (state_q != ST_HALT) && !redirect && !halt
                      && (occupancy < DEPTH_W);
  assign mem_addr   = fetch_pc_q;
  assign grant      = mem_req && mem_gnt;
  assign push       = (state_q == ST_PEND) && mem_rvalid && !redirect;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && !stall && !redirect;

  assign inst    = inst_valid ? inst_mem_q[rd_ptr_q] : NOP;
  assign inst_pc = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign count   = count_q;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (redirect) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc & ~32'h3;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (halt) begin
        state_d = ST_HALT;
      end else if (state_q != ST_HALT) begin
        state_d = grant ? ST_PEND : ST_RUN;
      end

      if (grant) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (push) begin
        pc_mem_d[wr_ptr_q]   = pend_pc_q;
        inst_mem_d[wr_ptr_q] = mem_rdata;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule
